// File: rtl/mult4_accum_if.sv
// Beat/result bus between a 4x4 multiplier stage and its running-sum accumulator.
interface mult4_accum_if #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 5
);
    logic [7:0]       in_prod;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    // Producer/consumer side: drives beats and takes results.
    modport master (
        output in_prod, in_valid, in_last, flush, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf
    );

    // Accumulator side.
    modport slave (
        input  in_prod, in_valid, in_last, flush, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf
    );
endinterface

// File: rtl/mult4_accum.sv
// Accumulates unsigned 8-bit products into a wrapping ACC_W-bit sum with a
// saturating term count and sticky overflow, then holds the result until the
// consumer takes it.
module mult4_accum #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    mult4_accum_if.slave      bus
);

    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    // Low through reset and until the first clock edge after release, so
    // in_ready cannot rise before the block has actually been clocked.
    logic             rdy_en_q, rdy_en_d;

    logic             accept;
    logic [ACC_W:0]   sum;

    // in_ready depends only on registered state and flush, never on out_ready.
    assign bus.in_ready  = rdy_en_q && (state_q == ACC) && !bus.flush;
    assign accept        = bus.in_valid && bus.in_ready;
    assign sum           = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, bus.in_prod};

    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_acc   = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.out_ovf   = ovf_q;

    // Next-state: accumulate in ACC, wait for the output handshake in HOLD.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        rdy_en_d = 1'b1;
        unique case (state_q)
            ACC: begin
                if (bus.flush) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (accept) begin
                    acc_d = sum[ACC_W-1:0];
                    ovf_d = ovf_q | sum[ACC_W];
                    if (cnt_q != {CNT_W{1'b1}})
                        cnt_d = cnt_q + 1'b1;
                    if (bus.in_last)
                        state_d = HOLD;
                end
            end
            HOLD: begin
                // flush and in_valid are deliberately ignored here.
                if (bus.out_ready) begin
                    state_d = ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // State and datapath registers; reset throws away any partial/pending sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACC;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            rdy_en_q <= rdy_en_d;
        end
    end

endmodule

// File: tb/tb_mult4_accum.sv
// Directed bench for mult4_accum: an unbounded-integer sum model checked every
// cycle, plus hand-computed expectations at the key points of each scenario.
module tb_mult4_accum;
    localparam int ACC_W = 10;
    localparam int CNT_W = 5;
    localparam longint ACC_MOD = 64'd1 << ACC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    mult4_accum_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    mult4_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the result is just the plain sum of accepted products and how many
    // there were; width effects are applied only when comparing.
    longint m_sum  = 0;
    int     m_n    = 0;
    bit     m_hold = 1'b0;
    bit     m_up   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sum = 0; m_n = 0; m_hold = 1'b0; m_up = 1'b0;
        end else begin
            if (!m_hold) begin
                if (bus.flush) begin
                    m_sum = 0; m_n = 0;
                end else if (m_up && bus.in_valid) begin
                    m_sum += bus.in_prod;
                    m_n++;
                    if (bus.in_last) m_hold = 1'b1;
                end
            end else if (bus.out_ready) begin
                m_hold = 1'b0; m_sum = 0; m_n = 0;
            end
            m_up = 1'b1;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("in_ready", bus.in_ready, (m_up && !m_hold && !bus.flush) ? 1 : 0);
        chk("out_valid", bus.out_valid, m_hold ? 1 : 0);
        if (m_hold) begin
            chk("out_acc", bus.out_acc, m_sum % ACC_MOD);
            chk("out_count", bus.out_count, (m_n > CNT_MAX) ? CNT_MAX : m_n);
            chk("out_ovf", bus.out_ovf, (m_sum >= ACC_MOD) ? 1 : 0);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] p, input logic last);
        bus.in_valid = 1'b1; bus.in_prod = p; bus.in_last = last;
        step();
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_prod = 8'h00;
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_result(input string tag, input int acc, input int cnt, input int ovf);
        chk({tag, ".valid"}, bus.out_valid, 1);
        chk({tag, ".acc"}, bus.out_acc, acc);
        chk({tag, ".count"}, bus.out_count, cnt);
        chk({tag, ".ovf"}, bus.out_ovf, ovf);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_prod = 8'h00; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        #2;
        chk("rst.in_ready", bus.in_ready, 0);
        chk("rst.out_valid", bus.out_valid, 0);
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        chk("rel.in_ready_before_edge", bus.in_ready, 0);
        step();
        chk("rel.in_ready", bus.in_ready, 1);

        // Basic sum
        send(8'd225, 1'b0); send(8'd12, 1'b0); send(8'd10, 1'b1);
        chk_result("basic", 247, 3, 0);

        // Backpressure; in_valid and flush in HOLD must not disturb the result
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_prod = 8'd99; bus.in_last = 1'b1;
            bus.flush = (i == 2);
            #1;
            chk("bp.in_ready", bus.in_ready, 0);
            step();
            chk_result("bp", 247, 3, 0);
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.flush = 1'b0;
        take();
        chk("bp.after_valid", bus.out_valid, 0);
        chk("bp.after_ready", bus.in_ready, 1);

        // Overflow: 5*225 = 1125 -> 1125-1024 = 101
        for (int i = 0; i < 5; i++) send(8'd225, i == 4);
        chk_result("ovf", 101, 5, 1);
        take();

        // Flush drops the partial sum and the concurrent beat
        send(8'd50, 1'b0); send(8'd50, 1'b0);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_prod = 8'd9;
        #1;
        chk("flush.in_ready", bus.in_ready, 0);
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush.no_out", bus.out_valid, 0);
        send(8'd7, 1'b1);
        chk_result("flush", 7, 1, 0);
        take();

        // Count saturation
        for (int i = 0; i < 40; i++) send(8'd1, i == 39);
        chk_result("sat", 40, 31, 0);
        take();

        // in_last without in_valid does nothing
        bus.in_last = 1'b1; bus.in_prod = 8'd33;
        step();
        bus.in_last = 1'b0;
        chk("lastnov.valid", bus.out_valid, 0);

        // Reset while holding a result
        send(8'd3, 1'b1);
        chk_result("prerst", 3, 1, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_hold.valid", bus.out_valid, 0);
        chk("rst_hold.in_ready", bus.in_ready, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        send(8'd0, 1'b1);
        chk_result("postrst", 0, 1, 0);
        take();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mult4_accum.md
MULT4_ACCUM -- requirements
Module: mult4_accum

Interface
REQ-001 Parameter ACC_W, default 16, accumulator and result width in bits; legal range 9..32.
REQ-002 Parameter CNT_W, default 5, term-counter width in bits; legal range 1..16.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_prod  input  8  unsigned product driven by the 4x4 array multiplier output o[7:0].
REQ-006 in_valid  input  1  in_prod and in_last are valid this cycle.
REQ-007 in_last  input  1  the current beat is the final term of the sum.
REQ-008 in_ready  output  1  the block accepts a beat this cycle.
REQ-009 flush  input  1  synchronous discard of the partial sum.
REQ-010 out_valid  output  1  the result fields are valid.
REQ-011 out_ready  input  1  the consumer takes the result this cycle.
REQ-012 out_acc  output  ACC_W  registered sum of all accepted products, modulo 2^ACC_W.
REQ-013 out_count  output  CNT_W  number of terms accepted, saturating.
REQ-014 out_ovf  output  1  sticky flag: the sum exceeded 2^ACC_W-1.

Function
REQ-015 The block SHALL have exactly two states: ACC, which accepts beats, and HOLD, which presents the result.
REQ-016 in_ready SHALL equal (state==ACC) AND NOT flush, combinationally.
REQ-017 A beat is accepted when in_valid AND in_ready are both 1.
REQ-018 On each accepted beat:
- acc <= acc + zero-extended in_prod, wrapping at ACC_W bits;
- ovf <= ovf OR carry-out of that addition;
- cnt <= cnt + 1, saturating at 2^CNT_W-1.
REQ-019 An accepted beat with in_last=1 SHALL move the state to HOLD and assert out_valid in the next cycle.
- That cycle's product is included in out_acc.
- Latency from the last accepted beat to out_valid is 1 cycle.
REQ-020 In HOLD:
- out_acc, out_count and out_ovf SHALL remain stable while out_valid=1 and out_ready=0;
- in_valid SHALL be ignored.
REQ-021 A HOLD cycle with out_ready=1 is the output handshake.
- Next cycle: out_valid=0, state ACC, in_ready=1.
- acc, cnt and ovf are cleared to 0.
REQ-022 flush=1 in ACC SHALL clear acc, cnt and ovf next cycle and produce no output.
- A concurrent in_valid beat is not accepted, since in_ready=0.
REQ-023 flush=1 in HOLD SHALL have no effect; the pending result is kept.
REQ-024 out_acc, out_count and out_ovf SHALL be registered and reflect the internal acc, cnt and ovf at all times.
- They are meaningful only while out_valid=1.
REQ-025 in_last with in_valid=0 SHALL have no effect.
REQ-026 A single accepted beat with in_last=1 from the cleared state SHALL produce out_count=1.
REQ-027 No combinational path SHALL exist from out_ready to in_ready.

Reset
REQ-028 On rst_n=0, the block SHALL immediately set state=ACC, acc=0, cnt=0, ovf=0 and out_valid=0, asynchronously.
REQ-029 While rst_n=0, in_ready SHALL be 0.
REQ-030 From the first rising edge after rst_n deasserts, in_ready SHALL be 1 unless flush=1.
REQ-031 A reset during HOLD or mid-sum SHALL discard all partial or pending results.

Verification
REQ-032 Basic sum: beats 225, 12, 10 (last on 10) -> out_valid=1 one cycle after the last beat, out_acc=247, out_count=3, out_ovf=0.
REQ-033 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid, out_acc and out_count stable and in_ready=0 throughout; after out_ready=1 -> in_ready=1 the next cycle.
REQ-034 Overflow (ACC_W=10): five beats of 225, last on the fifth -> out_acc=101, out_ovf=1, out_count=5.
REQ-035 Flush: two beats of 50, then flush=1 with in_valid=1 and prod=9 -> that beat is not accepted; then a single last beat of 7 -> out_acc=7, out_count=1.
REQ-036 Saturation (CNT_W=5): 40 beats of 1, last on the 40th -> out_count=31, out_acc=40.
REQ-037 Reset mid-HOLD: rst_n=0 while out_valid=1 -> out_valid=0 immediately; after release, a last beat of 0 -> out_acc=0, out_count=1.
